// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and default widths for the SPI request arbiter
package spi_arb_pkg;
    localparam int N_DEF = 4;
    localparam int M_DEF = 15;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } state_t;
endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner, searching upward from last+1 with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  win
);
    logic [LW-1:0] j;
    // walk the rotation backwards so the nearest requester after last wins
    always_comb begin
        win = '0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = LW'((int'(last) + k) % N);
            if (req[j]) win = N'(1) << j;
        end
    end
endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one SPI master among N requesters, round-robin, one transaction at a time.
// Define SPI_ARB_TIMEOUT_EN to compile in a watchdog that aborts a transaction after TO_CYCLES cycles.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int M         = M_DEF,
    parameter int TO_CYCLES = 4096
) (
    input  logic         GCLK,
    input  logic         RST,
    input  logic [N-1:0] req,
    input  logic [N*M-1:0] tx_data,
    output logic [N-1:0] grant,
    output logic [N-1:0] done,
    output logic [N-1:0] err,
    output logic [M-1:0] rx_data,
    output logic         busy,
    output logic         spi_st,
    output logic [M-1:0] spi_tx,
    input  logic         spi_ss,
    input  logic [M-1:0] spi_rx
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    state_t        state, state_nxt;
    logic [LW-1:0] last, widx;
    logic [N-1:0]  win;
    logic [M-1:0]  words [N];
    logic          take, fin, expire, quit;

    for (genvar g = 0; g < N; g++) begin : g_words
        assign words[g] = tx_data[g*M +: M];
    end

    rr_pick #(.N(N), .LW(LW)) u_pick (
        .req (req),
        .last(last),
        .win (win)
    );

    assign busy   = state != IDLE;
    assign spi_st = state == START;
    assign quit   = expire && !fin;

    // encode the one-hot winner as an index for the TX mux and the rotation pointer
    always_comb begin
        widx = '0;
        for (int k = 0; k < N; k++)
            if (win[k]) widx = LW'(k);
    end

    // next state; a completing frame takes precedence over a same-cycle timeout
    always_comb begin
        state_nxt = state;
        take = 1'b0;
        fin = 1'b0;
        unique case (state)
            IDLE: begin
                take = |req;
                state_nxt = take ? START : IDLE;
            end
            START: state_nxt = expire ? GAP : (!spi_ss ? XFER : START);
            XFER: begin
                fin = spi_ss;
                state_nxt = (spi_ss || expire) ? GAP : XFER;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign expire = (state == START || state == XFER) && cnt == CW'(TO_CYCLES - 1);
    // watchdog: zero outside START/XFER, so it is clear on every START entry
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
            err <= '0;
        end else begin
            cnt <= (state == START || state == XFER) ? cnt + 1'b1 : '0;
            err <= quit ? grant : '0;
        end
    end
`else
    assign expire = 1'b0;
    assign err    = '0;
`endif

    // state register, grant/TX latch on award, RX capture and done pulse on completion
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            grant   <= '0;
            done    <= '0;
            rx_data <= '0;
            spi_tx  <= '0;
            last    <= LW'(N - 1);
        end else begin
            state <= state_nxt;
            done  <= fin ? grant : '0;
            if (take) begin
                grant  <= win;
                spi_tx <= words[widx];
                last   <= widx;
            end else if (fin || quit) begin
                grant <= '0;
            end
            if (fin) rx_data <= spi_rx;
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed scoreboard bench for spi_req_arbiter with a simple SPI master model
module tb_spi_req_arbiter;
    localparam int N = 4;
    localparam int M = 15;

    logic           GCLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   req = '0;
    logic [M-1:0]   tx [N];
    logic [N*M-1:0] tx_data;
    logic [N-1:0]   grant, done, err;
    logic [M-1:0]   rx_data, spi_tx;
    logic           busy, spi_st;
    logic           spi_ss = 1'b1;
    logic [M-1:0]   spi_rx = '0;

    typedef struct {
        int           kind;
        logic [N-1:0] vec;
        logic [M-1:0] data;
    } ev_t;

    ev_t          exp_q[$];
    int           checks = 0;
    int           failures = 0;
    logic [N-1:0] prev_g = '0;

    spi_req_arbiter #(.N(N), .M(M), .TO_CYCLES(64)) dut (
        .GCLK   (GCLK),
        .RST    (RST),
        .req    (req),
        .tx_data(tx_data),
        .grant  (grant),
        .done   (done),
        .err    (err),
        .rx_data(rx_data),
        .busy   (busy),
        .spi_st (spi_st),
        .spi_tx (spi_tx),
        .spi_ss (spi_ss),
        .spi_rx (spi_rx)
    );

    always #5 GCLK = ~GCLK;
    assign tx_data = {tx[3], tx[2], tx[1], tx[0]};

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [N-1:0] vec, input logic [M-1:0] data);
        exp_q.push_back('{kind: kind, vec: vec, data: data});
    endtask

    task automatic pop_cmp(input int kind, input logic [N-1:0] vec, input logic [M-1:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d vec %0h data %0h expected none", kind, vec, data);
        end else begin
            e = exp_q.pop_front();
            cmp("event_kind", kind, e.kind);
            cmp("event_vec", 32'(vec), 32'(e.vec));
            cmp("event_data", 32'(data), 32'(e.data));
        end
    endtask

    // monitor: kind 0 = new grant (with latched TX word), 1 = done, 2 = err
    always @(negedge GCLK) begin
        if (grant != 0 && prev_g == 0) pop_cmp(0, grant, spi_tx);
        if (done != 0) pop_cmp(1, done, rx_data);
        if (err != 0) pop_cmp(2, err, rx_data);
        prev_g = grant;
    end

    task automatic wait_st();
        int n = 0;
        while (!spi_st && n < 20) begin
            @(negedge GCLK);
            n++;
        end
        cmp("spi_st_wait", 32'(spi_st), 1);
    endtask

    task automatic run_xfer(input logic [M-1:0] rx, input int hold, input int chg, input logic [N-1:0] nreq);
        wait_st();
        spi_ss = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge GCLK);
            if (i + 1 == chg) begin
                req = nreq;
                for (int k = 0; k < N; k++) tx[k] = ~tx[k];
            end
        end
        spi_rx = rx;
        spi_ss = 1'b1;
        @(negedge GCLK);
        cmp("done_latency", 32'(|done), 1);
    endtask

    task automatic reset_pulse();
        @(negedge GCLK);
        RST = 1'b0;
        repeat (2) @(negedge GCLK);
        RST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) tx[k] = '0;
        #1 RST = 1'b0;
        #1;
        cmp("rst_grant", 32'(grant), 0);
        cmp("rst_done", 32'(done), 0);
        cmp("rst_err", 32'(err), 0);
        cmp("rst_rx_data", 32'(rx_data), 0);
        cmp("rst_spi_tx", 32'(spi_tx), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_spi_st", 32'(spi_st), 0);
        repeat (2) @(negedge GCLK);
        RST = 1'b1;

        // single request from requester 1
        tx[1] = 15'h2A5A;
        push(0, 4'b0010, 15'h2A5A);
        push(1, 4'b0010, 15'h1234);
        req = 4'b0010;
        @(negedge GCLK);
        cmp("req_to_st_latency", 32'(spi_st), 1);
        req = '0;
        run_xfer(15'h1234, 3, -1, '0);
        @(negedge GCLK);
        cmp("gap_then_idle_busy", 32'(busy), 0);

        // contention: all four requesting from reset
        reset_pulse();
        for (int k = 0; k < N; k++) tx[k] = 15'h0100 + 15'(k);
        for (int k = 0; k < 8; k++) begin
            push(0, 4'(1 << (k % 4)), 15'h0100 + 15'(k % 4));
            push(1, 4'(1 << (k % 4)), 15'h0500 + 15'(k));
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) run_xfer(15'h0500 + 15'(k), 2, -1, '0);
        req = '0;

        // back-to-back on requester 0
        push(0, 4'b0001, 15'h0100);
        push(1, 4'b0001, 15'h00AA);
        push(0, 4'b0001, 15'h0100);
        push(1, 4'b0001, 15'h00BB);
        req = 4'b0001;
        run_xfer(15'h00AA, 2, -1, '0);
        @(negedge GCLK);
        cmp("b2b_idle_no_st", 32'(spi_st), 0);
        @(negedge GCLK);
        cmp("b2b_st_two_after_done", 32'(spi_st), 1);
        run_xfer(15'h00BB, 2, -1, '0);
        req = '0;

        // withdrawal of req[2] plus TX words changing after the latch
        tx[0] = 15'h0AAA;
        tx[2] = 15'h0333;
        push(0, 4'b0100, 15'h0333);
        push(1, 4'b0100, 15'h0777);
        push(0, 4'b0001, 15'h7555);
        push(1, 4'b0001, 15'h0666);
        req = 4'b0100;
        run_xfer(15'h0777, 5, 3, 4'b0001);
        cmp("tx_held_after_latch", 32'(spi_tx), 32'h0333);
        run_xfer(15'h0666, 2, -1, '0);
        req = '0;

        // reset in the middle of XFER
        tx[1] = 15'h0F0F;
        push(0, 4'b0010, 15'h0F0F);
        req = 4'b0010;
        wait_st();
        spi_ss = 1'b0;
        repeat (2) @(negedge GCLK);
        cmp("in_xfer_busy", 32'(busy), 1);
        #2 RST = 1'b0;
        #1;
        cmp("abort_grant", 32'(grant), 0);
        cmp("abort_busy", 32'(busy), 0);
        cmp("abort_spi_st", 32'(spi_st), 0);
        cmp("abort_spi_tx", 32'(spi_tx), 0);
        cmp("abort_rx_data", 32'(rx_data), 0);
        cmp("abort_done", 32'(done), 0);
        repeat (2) @(negedge GCLK);
        push(0, 4'b0100, 15'h7CCC);
        push(1, 4'b0100, 15'h0123);
        req = 4'b1100;
        spi_ss = 1'b1;
        RST = 1'b1;
        run_xfer(15'h0123, 2, -1, '0);
        req = '0;

`ifdef SPI_ARB_TIMEOUT_EN
        // watchdog: the master never selects the slave
        begin
            int n = 0;
            push(0, 4'b0001, 15'h7555);
            push(2, 4'b0001, 15'h0123);
            req = 4'b0001;
            wait_st();
            req = '0;
            while (err == 0 && n < 100) begin
                @(negedge GCLK);
                n++;
            end
            cmp("timeout_cycles", 32'(n), 64);
            @(negedge GCLK);
            cmp("timeout_busy_drop", 32'(busy), 0);
        end
`endif

        repeat (3) @(negedge GCLK);
        cmp("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
